icb_ram_slv: RTL
================

# icb_ram_slv

ICB responder that terminates the core's data-side ICB bus on a local single-port word RAM. Accepts one command at a time, performs the byte-masked write or the read, and returns exactly one response per accepted command. It is the far end of the core's bus/stall controller, which issues commands, holds `rsp_ready` high and stalls until the read response arrives.

## Interface
Parameters:
- `ADDR_W`, 12: RAM word-address width; depth = 2**ADDR_W words of 32 bits.
- `BASE_ADDR`, 32'h2000_0000: byte base address of the RAM window; must be aligned to 4*2**ADDR_W.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `icb_cmd_valid`  in  1  command valid.
- `icb_cmd_ready`  out  1  command accepted when high together with valid.
- `icb_cmd_addr`  in  32  byte address; bits [1:0] ignored.
- `icb_cmd_read`  in  1  1 = read, 0 = write.
- `icb_cmd_wdata`  in  32  write data.
- `icb_cmd_wmask`  in  4  byte-lane write enable; bit i writes wdata[8i+7:8i].
- `icb_rsp_valid`  out  1  response valid.
- `icb_rsp_ready`  in  1  response consumed when high together with valid.
- `icb_rsp_err`  out  1  response error flag.
- `icb_rsp_rdata`  out  32  read data.

## Operation
- States: IDLE (no response pending), RSP (`icb_rsp_valid`=1).
- `icb_cmd_ready` = (state==IDLE) | (icb_rsp_valid & icb_rsp_ready); at most one transaction outstanding, full throughput when the master takes responses immediately.
- Accept (`cmd_valid & cmd_ready`): decode hit = addr in [BASE_ADDR, BASE_ADDR + 4*2**ADDR_W). Word index = addr[ADDR_W+1:2].
  - Hit, write: RAM lanes with `wmask` bit set updated at the accepting edge; other lanes unchanged. `wmask`=0 is a legal no-op write.
  - Hit, read: RAM read enabled at the accepting edge.
  - Miss: no RAM access; response carries err.
  - Latched at accept: is_read, err.
- IDLE -> RSP on accept. RSP -> IDLE on rsp handshake without new accept. RSP -> RSP on handshake plus simultaneous accept (new response).
- While in RSP without handshake: all rsp outputs hold stable; the RAM is not accessed.
- `icb_rsp_rdata` = RAM output when latched is_read & ~err, else 32'h0. Write responses have rdata 0, err 0 on hit.
- `icb_rsp_err` = latched err, valid only with `icb_rsp_valid`.

## Timing
- Reset values: `icb_rsp_valid`=0, `icb_rsp_err`=0, `icb_rsp_rdata`=0, `icb_cmd_ready`=1, state IDLE, latched is_read=0.
- Accept in cycle N -> `icb_rsp_valid`=1 in cycle N+1 (read and write, hit and miss).
- Read data is registered in the RAM; no combinational path from cmd inputs to rsp outputs. `icb_cmd_ready` depends combinationally on `icb_rsp_ready`.
- Write at edge N followed by read of same word accepted at edge N+1 returns the written data.
- Reset mid-transaction: pending response discarded, RAM contents undefined (not cleared).
- `icb_cmd_*` other than valid sampled only on accept cycle.

## Configuration
- `ICB_RAM_ERR_EN` defined: out-of-window accesses respond with `icb_rsp_err`=1, rdata 0, no RAM side effect.
- Not defined: no address decode; every access hits, word index = addr[ADDR_W+1:2] (window aliases across the address space); `icb_rsp_err` tied 0.

## Structure
- Bus widths (`MemBus`, `MemAddrBus`) come from the shared defines header; no new shared constants.
- Sub-module `ram_sp`: single-port, 2**ADDR_W x 32, per-byte write enable, registered read output held when not enabled. Top holds FSM, decode and response register.

## Test plan
- Write 32'hDEADBEEF mask 4'hF to BASE_ADDR+8, then read it -> rsp_valid one cycle after each accept, read rdata 32'hDEADBEEF, err 0.
- Write 32'h0000_5500 mask 4'b0010 over that word, read -> rdata 32'hDEADBEEF with byte1 replaced: 32'hDEAD55EF.
- Back-to-back reads of 8 consecutive words with rsp_ready=1 -> cmd_ready stays 1, one response per cycle, data in order.
- rsp_ready held 0 for 5 cycles after a read -> cmd_ready 0, rsp_valid/rdata stable, new cmd not accepted; accepted in handshake cycle when ready rises.
- With `ICB_RAM_ERR_EN`, read at BASE_ADDR-4 -> err 1, rdata 0; write there leaves RAM unchanged. Without macro, read at BASE_ADDR + 4*2**ADDR_W -> returns word 0, err 0.
- Assert rst_n low while rsp_valid=1 -> rsp_valid, err, rdata 0 immediately; cmd_ready 1.

Source files
------------

// File: rtl/icb_ram_slv_pkg.sv
// Shared types and bus widths for the ICB RAM responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icb_ram_slv_pkg;

  // Data-side bus widths of the core
  localparam int MemBus     = 32;
  localparam int MemAddrBus = 32;
  localparam int MemMaskBus = MemBus / 8;

  // Response FSM: IDLE = no response pending, RSP = response on the bus
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_t;

endpackage

// File: rtl/icb_ram_slv_ram_sp.sv
// Single-port word RAM with per-byte write enable and a registered read port.
// Latency: read data valid one cycle after a cycle with re=1; held while re=0.
// Backpressure: none; the caller gates re/we so the output stays stable.
// Ports: clk; re (read enable); we[3:0] (byte-lane write enables);
//        addr (word index); wdata (write data); rdata (registered read data).
module icb_ram_slv_ram_sp
  import icb_ram_slv_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [MemMaskBus-1:0] we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [MemBus-1:0]     wdata,
  output logic [MemBus-1:0]     rdata
);

  logic [MemBus-1:0] mem [2**ADDR_W];

  // Contents are deliberately not reset: the array maps onto a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MemMaskBus; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/icb_ram_slv.sv
// ICB responder terminating the data-side bus on a local word RAM.
// Latency: response one cycle after command accept (read, write, hit or miss).
// Backpressure: one transaction outstanding; cmd_ready drops while a response
//   waits, and rises combinationally in the cycle rsp_ready consumes it.
// Ports: clk, rst_n (async active-low); icb_cmd_{valid,ready,addr,read,wdata,
//   wmask} command channel; icb_rsp_{valid,ready,err,rdata} response channel.
// Build option: define ICB_RAM_ERR_EN to decode the address window and answer
//   out-of-window accesses with err=1; otherwise the window aliases everywhere.
module icb_ram_slv
  import icb_ram_slv_pkg::*;
#(
  parameter int                    ADDR_W    = 12,
  parameter logic [MemAddrBus-1:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [MemAddrBus-1:0] icb_cmd_addr,
  input  logic                  icb_cmd_read,
  input  logic [MemBus-1:0]     icb_cmd_wdata,
  input  logic [MemMaskBus-1:0] icb_cmd_wmask,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic                  icb_rsp_err,
  output logic [MemBus-1:0]     icb_rsp_rdata
);

  state_t                state_q, state_d;
  logic                  is_read_q;
  logic                  rsp_hs;
  logic                  accept;
  logic                  hit;
  logic                  ram_re;
  logic [MemMaskBus-1:0] ram_we;
  logic [MemBus-1:0]     ram_rdata;
  logic                  unused_addr;

`ifdef ICB_RAM_ERR_EN
  // Window is naturally aligned, so a masked compare decodes it.
  localparam logic [MemAddrBus-1:0] WIN_MASK =
      ~((MemAddrBus'(4) << ADDR_W) - MemAddrBus'(1));

  logic err_q;

  assign hit         = (icb_cmd_addr & WIN_MASK) == BASE_ADDR;
  assign unused_addr = ^icb_cmd_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= ~hit;
  end

  assign icb_rsp_err = err_q;
`else
  logic err_q;

  // No decode: every access hits and the upper address bits alias.
  assign hit         = 1'b1;
  assign err_q       = 1'b0;
  assign unused_addr = ^{icb_cmd_addr[MemAddrBus-1:ADDR_W+2], icb_cmd_addr[1:0]};
  assign icb_rsp_err = 1'b0;
`endif

  assign icb_rsp_valid = (state_q == ST_RSP);
  assign rsp_hs        = icb_rsp_valid & icb_rsp_ready;
  assign icb_cmd_ready = (state_q == ST_IDLE) | rsp_hs;
  assign accept        = icb_cmd_valid & icb_cmd_ready;

  // RAM is touched only on an accepted in-window command, so a stalled
  // response keeps its read data untouched.
  assign ram_re = accept & hit & icb_cmd_read;
  assign ram_we = (accept & hit & ~icb_cmd_read) ? icb_cmd_wmask : '0;

  icb_ram_slv_ram_sp #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (icb_cmd_addr[ADDR_W+1:2]),
    .wdata (icb_cmd_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_read_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) is_read_q <= icb_cmd_read;
    end
  end

  // An accept always produces a new response; a handshake alone retires one.
  always_comb begin
    state_d = state_q;
    if (accept)      state_d = ST_RSP;
    else if (rsp_hs) state_d = ST_IDLE;
  end

  assign icb_rsp_rdata = (is_read_q & ~err_q) ? ram_rdata : '0;

endmodule
